// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the two-port register-file arbiter: FSM encoding,
// port identifiers and the default write-protected register address.
package regfile_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [3:0] ZERO_ADDR_DEFAULT = 4'd15;

endpackage

// File: rtl/regfile_arb_pick.sv
// Winner selection between the core (port 0) and debug (port 1) requesters.
// REGFILE_ARB_RR_EN selects round-robin on contention; otherwise port 0 always wins.
module regfile_arb_pick
    import regfile_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_win,
    output logic winner
);

    // With no request the output is a don't-care; last_win keeps it stable.
    always_comb begin
        winner = last_win;
        if (req0 && req1) begin
`ifdef REGFILE_ARB_RR_EN
            winner = ~last_win;
`else
            winner = PORT0;
`endif
        end else if (req0) begin
            winner = PORT0;
        end else if (req1) begin
            winner = PORT1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-port register-file access arbiter: IDLE -> ACCESS -> ACK per transfer.
// Define REGFILE_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int            AW        = 4,
    parameter int            DW        = 8,
    parameter logic [AW-1:0] ZERO_ADDR = AW'(ZERO_ADDR_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          we_reg,
    output logic [AW-1:0] addr_reg,
    output logic [DW-1:0] data_reg,
    input  logic [DW-1:0] out_reg
);

    state_e        state_q, state_d;
    logic          cmd_we_q, cmd_we_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic          win_q, win_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          last_win;
    logic          pick;
    logic          grant;
    logic          blocked;

`ifdef REGFILE_ARB_RR_EN
    logic last_win_q, last_win_d;
    assign last_win = last_win_q;
`else
    assign last_win = PORT1;
`endif

    regfile_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_win (last_win),
        .winner   (pick)
    );

    assign grant   = (state_q == ST_IDLE) && (req0 || req1);
    assign blocked = cmd_we_q && (cmd_addr_q == ZERO_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req0 || req1) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state alone, so an async reset clears them at once.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        we_reg   = (state_q == ST_ACCESS) && cmd_we_q && !blocked;
        ack0     = (state_q == ST_ACK) && (win_q == PORT0);
        ack1     = (state_q == ST_ACK) && (win_q == PORT1);
        err      = (state_q == ST_ACK) && blocked;
        addr_reg = cmd_addr_q;
        data_reg = cmd_wdata_q;
        rdata    = rdata_q;
    end

    always_comb begin
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        win_d       = win_q;
        rdata_d     = rdata_q;
`ifdef REGFILE_ARB_RR_EN
        last_win_d  = last_win_q;
`endif
        if (grant) begin
            win_d       = pick;
            cmd_we_d    = (pick == PORT1) ? we1    : we0;
            cmd_addr_d  = (pick == PORT1) ? addr1  : addr0;
            cmd_wdata_d = (pick == PORT1) ? wdata1 : wdata0;
`ifdef REGFILE_ARB_RR_EN
            last_win_d  = pick;
`endif
        end
        // Captured before any write lands, so a write returns the old contents.
        if (state_q == ST_ACCESS) begin
            rdata_d = out_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            win_q       <= PORT0;
            rdata_q     <= '0;
`ifdef REGFILE_ARB_RR_EN
            last_win_q  <= PORT1;
`endif
        end else begin
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            win_q       <= win_d;
            rdata_q     <= rdata_d;
`ifdef REGFILE_ARB_RR_EN
            last_win_q  <= last_win_d;
`endif
        end
    end

endmodule
